// File: rtl/mux_scan_nw_pkg.sv
// Shared constants and types for the scanning N-way multiplexer.
// Mode encoding, FSM states and a width helper.
package mux_scan_nw_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_nw.sv
// Combinational N-way, W-bit slice selector.
// An index with no matching channel yields zero.
module mux_nw #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   y
);

  // Pick the slice whose channel number equals idx.
  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) y = d[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_scan_nw.sv
// Registered N-way multiplexer with manual select and timed scan.
// Channel choice is computed combinationally, then registered with o.
module mux_scan_nw
  import mux_scan_nw_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SW    = 3,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   o,
  output logic [SW-1:0]  ch,
  output logic           o_valid,
  output logic           err,
  output logic           wrap
);

  localparam int CW = clog2(DWELL);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   nxt_ch;
  logic [W-1:0]    sel;
  logic            man;
  logic            enter;
  logic            step;
  logic            in_rng;
  logic            dwell_done;
  logic            last_ch;

  assign man        = (mode == MODE_MANUAL);
  assign enter      = !man && (state == ST_MANUAL);
  assign step       = !man && (state == ST_SCAN);
  assign in_rng     = ({1'b0, s} < (SW+1)'(N));
  assign dwell_done = (cnt == CW'(DWELL - 1));
  assign last_ch    = (ch == SW'(N - 1));

  // Channel to drive after the coming edge.
  always_comb begin
    nxt_ch = ch;
    unique case (1'b1)
      man:   nxt_ch = s;
      enter: nxt_ch = '0;
      step: begin
        if (dwell_done)
          nxt_ch = last_ch ? '0 : ch + SW'(1);
      end
      default: nxt_ch = ch;
    endcase
  end

  mux_nw #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_mux (
    .d   (d),
    .idx (nxt_ch),
    .y   (sel)
  );

  // Mode FSM, dwell counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_MANUAL;
      cnt     <= '0;
      ch      <= '0;
      o       <= '0;
      o_valid <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
    end else if (en) begin
      state   <= man ? ST_MANUAL : ST_SCAN;
      cnt     <= (step && !dwell_done) ? cnt + CW'(1) : '0;
      ch      <= nxt_ch;
      o       <= sel;
      o_valid <= man ? in_rng : 1'b1;
      err     <= man && !in_rng;
      wrap    <= step && dwell_done && last_ch;
    end else begin
      wrap    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_nw.sv
// Directed bench for mux_scan_nw: an 8-channel DWELL=4 instance
// and a 5-channel DWELL=1 instance share control inputs.
module tb_mux_scan_nw;

  logic        clk;
  logic        rst_n;
  logic [63:0] d8;
  logic [39:0] d5;
  logic [2:0]  s;
  logic        mode;
  logic        en;

  logic [7:0]  o8, o5;
  logic [2:0]  ch8, ch5;
  logic        v8, v5, e8, e5, w8, w5;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [2:0] s;
    logic       en;
    logic [2:0] ch;
    logic [7:0] o8;
    logic [7:0] o5;
    logic       v5;
    logic       e5;
  } vec_t;

  vec_t tbl[8];

  mux_scan_nw #(.N(8), .W(8), .SW(3), .DWELL(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .s(s), .mode(mode), .en(en),
    .o(o8), .ch(ch8), .o_valid(v8), .err(e8), .wrap(w8)
  );

  mux_scan_nw #(.N(5), .W(8), .SW(3), .DWELL(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .d(d5), .s(s), .mode(mode), .en(en),
    .o(o5), .ch(ch5), .o_valid(v5), .err(e5), .wrap(w5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_o8",  32'(o8),  32'h0);
    chk("rst_ch8", 32'(ch8), 32'h0);
    chk("rst_v8",  32'(v8),  32'h0);
    chk("rst_e8",  32'(e8),  32'h0);
    chk("rst_w8",  32'(w8),  32'h0);
    chk("rst_o5",  32'(o5),  32'h0);
    chk("rst_ch5", 32'(ch5), 32'h0);
    chk("rst_v5",  32'(v5),  32'h0);
    chk("rst_w5",  32'(w5),  32'h0);
  endtask

  initial begin
    int c8, c5;
    logic [7:0] x8, x5;
    logic xw8, xw5;
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'hA0 + 8'(k);

    //              s     en    ch    o8     o5     v5    e5
    tbl[0] = '{3'd5, 1'b1, 3'd5, 8'h15, 8'h00, 1'b0, 1'b1};
    tbl[1] = '{3'd2, 1'b1, 3'd2, 8'h12, 8'hA2, 1'b1, 1'b0};
    tbl[2] = '{3'd6, 1'b1, 3'd6, 8'h16, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{3'd7, 1'b0, 3'd6, 8'h16, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{3'd7, 1'b1, 3'd7, 8'h17, 8'h00, 1'b0, 1'b1};
    tbl[5] = '{3'd4, 1'b1, 3'd4, 8'h14, 8'hA4, 1'b1, 1'b0};
    tbl[6] = '{3'd0, 1'b1, 3'd0, 8'h10, 8'hA0, 1'b1, 1'b0};
    tbl[7] = '{3'd3, 1'b0, 3'd0, 8'h10, 8'hA0, 1'b1, 1'b0};

    rst_n = 1'b0;
    s     = 3'd0;
    mode  = 1'b0;
    en    = 1'b1;
    #2;
    chk_reset();
    rst_n = 1'b1;

    // Manual selection, out-of-range select, enable hold.
    for (int i = 0; i < 8; i++) begin
      s  = tbl[i].s;
      en = tbl[i].en;
      tick();
      chk("man_ch8", 32'(ch8), 32'(tbl[i].ch));
      chk("man_o8",  32'(o8),  32'(tbl[i].o8));
      chk("man_v8",  32'(v8),  32'h1);
      chk("man_e8",  32'(e8),  32'h0);
      chk("man_ch5", 32'(ch5), 32'(tbl[i].ch));
      chk("man_o5",  32'(o5),  32'(tbl[i].o5));
      chk("man_v5",  32'(v5),  32'(tbl[i].v5));
      chk("man_e5",  32'(e5),  32'(tbl[i].e5));
      chk("man_w8",  32'(w8),  32'h0);
    end

    // Scan: dut8 holds 4 cycles per channel, dut5 steps each cycle.
    en   = 1'b1;
    mode = 1'b1;
    for (int j = 1; j <= 47; j++) begin
      tick();
      c8  = ((j - 1) / 4) % 8;
      c5  = (j - 1) % 5;
      xw8 = (j > 1) && ((j - 1) % 32 == 0);
      xw5 = (j > 1) && ((j - 1) % 5 == 0);
      x8  = 8'h10 + 8'(c8);
      x5  = 8'hA0 + 8'(c5);
      chk("scan_ch8", 32'(ch8), 32'(c8));
      chk("scan_o8",  32'(o8),  32'(x8));
      chk("scan_w8",  32'(w8),  32'(xw8));
      chk("scan_ch5", 32'(ch5), 32'(c5));
      chk("scan_o5",  32'(o5),  32'(x5));
      chk("scan_w5",  32'(w5),  32'(xw5));
    end

    // dut8 now at ch=3, count=2; freeze for 10 cycles.
    en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("frz_ch8", 32'(ch8), 32'h3);
      chk("frz_o8",  32'(o8),  32'h13);
      chk("frz_w8",  32'(w8),  32'h0);
      chk("frz_ch5", 32'(ch5), 32'h1);
      chk("frz_w5",  32'(w5),  32'h0);
    end
    en = 1'b1;
    tick();
    chk("unfrz1_ch8", 32'(ch8), 32'h3);
    chk("unfrz1_ch5", 32'(ch5), 32'h2);
    tick();
    chk("unfrz2_ch8", 32'(ch8), 32'h4);
    chk("unfrz2_o8",  32'(o8),  32'h14);
    chk("unfrz2_ch5", 32'(ch5), 32'h3);

    // Advance dut8 to ch=6, then drop back to manual with s=1.
    for (int j = 0; j < 9; j++) tick();
    chk("pre_sw_ch8", 32'(ch8), 32'h6);
    chk("pre_sw_ch5", 32'(ch5), 32'h2);
    mode = 1'b0;
    s    = 3'd1;
    tick();
    chk("sw_ch8", 32'(ch8), 32'h1);
    chk("sw_o8",  32'(o8),  32'h11);
    chk("sw_v8",  32'(v8),  32'h1);
    chk("sw_w8",  32'(w8),  32'h0);
    chk("sw_ch5", 32'(ch5), 32'h1);
    chk("sw_o5",  32'(o5),  32'hA1);

    // Re-enter scan: restart at channel 0 with a fresh dwell.
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      c8 = (i < 4) ? 0 : 1;
      x8 = 8'h10 + 8'(c8);
      chk("rescan_ch8", 32'(ch8), 32'(c8));
      chk("rescan_o8",  32'(o8),  32'(x8));
      chk("rescan_ch5", 32'(ch5), 32'(i));
    end

    // Asynchronous reset mid-scan, checked before any clock edge.
    rst_n = 1'b0;
    #2;
    chk_reset();
    rst_n = 1'b1;
    tick();
    chk("rel_ch8", 32'(ch8), 32'h0);
    chk("rel_o8",  32'(o8),  32'h10);
    chk("rel_v8",  32'(v8),  32'h1);
    chk("rel_ch5", 32'(ch5), 32'h0);
    chk("rel_o5",  32'(o5),  32'hA0);
    for (int j = 0; j < 4; j++) tick();
    chk("rel4_ch8", 32'(ch8), 32'h1);
    chk("rel4_ch5", 32'(ch5), 32'h4);
    chk("rel4_o5",  32'(o5),  32'hA4);
    tick();
    chk("rel5_ch5", 32'(ch5), 32'h0);
    chk("rel5_w5",  32'(w5),  32'h1);
    chk("rel5_w8",  32'(w8),  32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_nw.md
Name: mux_scan_nw

Overview:
Parametrised N-channel, W-bit registered multiplexer with two modes. In manual mode the channel is chosen by an external select. In scan mode an internal counter steps through every channel, holding each for DWELL cycles. Sits between sensor/data sources and display or serial-out blocks; generalises the fixed 8:1 single-bit selector.

Parameters:
N, 8, number of input channels (2..2**SW)
W, 8, data width per channel in bits
SW, 3, select/channel-index width; N must be <= 2**SW
DWELL, 4, cycles each channel is held in scan mode (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
d  in  N*W  flattened channel inputs; channel k occupies d[k*W+W-1 : k*W]
s  in  SW  manual channel select
mode  in  1  0 = manual, 1 = scan; sampled every clk edge
en  in  1  clock enable; 0 freezes all state and outputs
o  out  W  registered selected data
ch  out  SW  channel index currently driven on o
o_valid  out  1  o holds valid data of channel ch
err  out  1  manual select out of range (s >= N)
wrap  out  1  one-cycle pulse when scan wraps from N-1 to 0

Behaviour:
- Reset (rst_n=0, async): o=0, ch=0, o_valid=0, err=0, wrap=0, dwell count=0, state=MANUAL. Release is synchronous to the next clk edge.
- Latency: 1 cycle. o and ch update on the same edge; o = d slice of the new ch, sampled at that edge.
- en=0: state, dwell count, ch, o, o_valid and err hold; wrap forced 0.
- FSM states: MANUAL, SCAN. Transitions are evaluated only when en=1.
  - MANUAL -> SCAN when mode=1.
  - SCAN -> MANUAL when mode=0.
- MANUAL, en=1, s<N: ch<=s, o<=d[s], o_valid<=1, err<=0.
- MANUAL, en=1, s>=N: ch<=s, o<=0, o_valid<=0, err<=1 (sticky only while s stays out of range).
- Entering SCAN (edge where state=MANUAL and mode=1): ch<=0, o<=d[0], dwell count<=0, o_valid<=1, err<=0.
- In SCAN, en=1, at each edge:
  - if count<DWELL-1: count++, ch holds, o<=d[ch] (live refresh).
  - else: count<=0; ch<=(ch==N-1)?0:ch+1; o<=d[next ch]; wrap<=1 iff ch==N-1.
- SCAN -> MANUAL (mode=0): same edge behaves as MANUAL with current s; dwell count<=0.
- wrap is 0 in every cycle that is not the wrap edge, and always 0 in MANUAL.
- DWELL=1: channel advances every enabled cycle.
- N not a power of two: wrap occurs at N-1, never visits indices >= N.
- Reset asserted mid-scan: immediate return to reset values; after release, state=MANUAL regardless of mode; scan restarts at channel 0 on the next enabled edge with mode=1.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package: mode constants MODE_MANUAL=0, MODE_SCAN=1; FSM state encoding ST_MANUAL, ST_SCAN; clog2 helper function.
- One natural sub-module: mux_nw. Purely combinational, parametrised N/W/SW. Selects a W-bit slice by index and returns zero for an out-of-range index. It is instantiated once, fed by the next-channel value.

Test Plan:
- Reset: drive rst_n=0 mid-operation with d nonzero -> o=0, ch=0, o_valid=0, err=0, wrap=0 immediately, without waiting for a clk edge.
- Manual select (N=8, W=8): d channel k = 8'h10+k, mode=0, s=5 -> one edge later o=8'h15, ch=5, o_valid=1.
- Out-of-range select (N=5, SW=3): s=6 -> o=0, o_valid=0, err=1; then s=2 -> o=d[2], err=0.
- Scan timing (N=8, DWELL=4): mode=1 -> ch=0 for 4 cycles, then ch=1 … ch=7; next advance gives ch=0 with wrap=1 for exactly one cycle. Period is 32 cycles.
- Enable freeze: in SCAN at ch=3, count=2, hold en=0 for 10 cycles -> ch, o, count unchanged and wrap=0. After en=1, ch advances to 4 after 2 more edges (count reaches 3, then wraps to 0 with ch=4).
- Mode switch: in SCAN at ch=6, set mode=0, s=1 -> next edge ch=1, o=d[1]. Set mode=1 again -> scan restarts at ch=0 with count=0.
